// File: rtl/seq_divider_16bit.sv
// Sequential restoring unsigned divider: one quotient bit per clock, start/busy/done handshake.
// Optional macro DIV_ZERO_DETECT_EN: a zero divisor completes immediately and raises o_div_err.
module seq_divider_16bit #(
   parameter int WIDTH = 16
) (
   input  logic             i_clk,
   input  logic             i_rst_n,
   input  logic             i_start,
   input  logic [WIDTH-1:0] i_dividend,
   input  logic [WIDTH-1:0] i_divisor,
   output logic             o_busy,
   output logic             o_done,
   output logic [WIDTH-1:0] o_quotient,
   output logic [WIDTH-1:0] o_remainder,
   output logic             o_div_err
);

   localparam int CW = $clog2(WIDTH + 1);

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

   state_t           r_state;
   state_t           w_state_nxt;
   logic [CW-1:0]    r_cnt;
   logic [WIDTH:0]   r_part;
   logic [WIDTH-1:0] r_q;
   logic [WIDTH-1:0] r_div;
   logic [WIDTH-1:0] r_quot;
   logic [WIDTH-1:0] r_rem;

   logic             w_accept;
   logic             w_last;
   logic             w_zero_skip;
   logic [WIDTH:0]   w_shift;
   logic [WIDTH+1:0] w_trial;
   logic             w_borrow;
   logic [WIDTH:0]   w_part_nxt;
   logic [WIDTH-1:0] w_q_nxt;

   // A new request is only taken while not busy; DONE counts as not busy.
   assign w_accept = i_start && (r_state != S_RUN);
   assign w_last   = (r_cnt == CW'(1));

`ifdef DIV_ZERO_DETECT_EN
   logic r_err;
   assign w_zero_skip = (i_divisor == '0);
   assign o_div_err   = r_err;
`else
   assign w_zero_skip = 1'b0;
   assign o_div_err   = 1'b0;
`endif

   // Trial subtraction carries one extra bit so the borrow is visible even
   // when the shifted partial remainder uses its 17th bit.
   assign w_shift    = {r_part[WIDTH-1:0], r_q[WIDTH-1]};
   assign w_trial    = {1'b0, w_shift} - {2'b00, r_div};
   assign w_borrow   = w_trial[WIDTH+1];
   assign w_part_nxt = w_borrow ? w_shift : w_trial[WIDTH:0];
   assign w_q_nxt    = {r_q[WIDTH-2:0], ~w_borrow};

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_IDLE, S_DONE: begin
            if (w_accept) w_state_nxt = w_zero_skip ? S_DONE : S_RUN;
            else          w_state_nxt = S_IDLE;
         end
         S_RUN:   if (w_last) w_state_nxt = S_DONE;
         default: w_state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         r_state <= S_IDLE;
         r_cnt   <= '0;
         r_part  <= '0;
         r_q     <= '0;
         r_div   <= '0;
         r_quot  <= '0;
         r_rem   <= '0;
`ifdef DIV_ZERO_DETECT_EN
         r_err   <= 1'b0;
`endif
      end else begin
         r_state <= w_state_nxt;
         if (w_accept) begin
            r_div  <= i_divisor;
            r_q    <= i_dividend;
            r_part <= '0;
            r_cnt  <= CW'(WIDTH);
`ifdef DIV_ZERO_DETECT_EN
            r_err  <= w_zero_skip;
            if (w_zero_skip) begin
               r_quot <= '1;
               r_rem  <= i_dividend;
            end
`endif
         end else if (r_state == S_RUN) begin
            r_part <= w_part_nxt;
            r_q    <= w_q_nxt;
            r_cnt  <= r_cnt - CW'(1);
            if (w_last) begin
               r_quot <= w_q_nxt;
               r_rem  <= w_part_nxt[WIDTH-1:0];
            end
         end
      end
   end

   assign o_busy      = (r_state == S_RUN);
   assign o_done      = (r_state == S_DONE);
   assign o_quotient  = r_quot;
   assign o_remainder = r_rem;

endmodule
